// File: rtl/pedestrian_crossing_ctrl.sv
// N-channel pedestrian signal controller: request latch, timed green/flash, done/clear
// handshake, minimum-red hold, shared 1-s prescaler and a global service blink mode.
module pedestrian_crossing_ctrl #(
   parameter int N_CH        = 2,
   parameter int TICK_DIV    = 10,
   parameter int GREEN_SEC   = 10,
   parameter int FLASH_SEC   = 10,
   parameter int MIN_RED_SEC = 3,
   parameter int REQ_MODE    = 1,
   parameter int CNT_W       = 6
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            service_i,
   input  logic [N_CH-1:0] enable_i,
   input  logic [N_CH-1:0] clear_i,
   input  logic [N_CH-1:0] request_i,
   output logic [N_CH-1:0] green_o,
   output logic [N_CH-1:0] red_o,
   output logic [N_CH-1:0] done_o,
   output logic [N_CH-1:0] pending_o,
   output logic            tick_o
);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0]    PRE_LAST   = PW'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_SEC - 1);
   localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_SEC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((MIN_RED_SEC > 0) ? MIN_RED_SEC - 1 : 0);
   localparam logic             HAS_HOLD   = (MIN_RED_SEC > 0);
   localparam logic             REQ_GATE   = (REQ_MODE != 0);

   typedef enum logic [2:0] {IDLE, GREEN, FLASH, DONE, HOLD} state_t;

   logic [PW-1:0] presc;
   logic          tick;
   logic          svc_q;
   logic          blink;

   assign tick   = (presc == PRE_LAST);
   assign tick_o = tick;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         presc <= '0;
         svc_q <= 1'b0;
         blink <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         svc_q <= service_i;
         // blink restarts dark every time service mode is entered
         if (!svc_q)
            blink <= 1'b0;
         else if (tick)
            blink <= ~blink;
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      state_t           state;
      logic [CNT_W-1:0] cnt;
      logic             pend;

      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i || service_i) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
         end else begin
            if (request_i[c] && state != GREEN)
               pend <= 1'b1;
            case (state)
               IDLE: begin
                  if (enable_i[c] && (pend || !REQ_GATE)) begin
                     state <= GREEN;
                     cnt   <= '0;
                     pend  <= 1'b0;  // a request in the grant cycle is served by this phase
                  end
               end
               GREEN: begin
                  if (tick) begin
                     if (cnt == GREEN_LAST) begin
                        state <= FLASH;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               FLASH: begin
                  if (tick) begin
                     if (cnt == FLASH_LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               DONE: begin
                  if (clear_i[c]) begin
                     state <= HAS_HOLD ? HOLD : IDLE;
                     cnt   <= '0;
                  end
               end
               HOLD: begin
                  if (tick) begin
                     if (cnt == HOLD_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign green_o[c]   = svc_q ? blink
                                  : ((state == GREEN) || ((state == FLASH) && !cnt[0]));
      assign red_o[c]     = !svc_q && (state != GREEN) && (state != FLASH);
      assign done_o[c]    = !svc_q && (state == DONE);
      assign pending_o[c] = pend;
   end
endmodule

// File: tb/tb_pedestrian_crossing_ctrl.sv
// Randomized and directed bench for pedestrian_crossing_ctrl against a tick-counting reference model.
module tb_pedestrian_crossing_ctrl;
   localparam int N   = 2;
   localparam int TD  = 10;
   localparam int GS  = 10;
   localparam int FS  = 10;
   localparam int MRS = 3;
   localparam int RQM = 1;

   logic clk;
   logic reset_i, service_i;
   logic [N-1:0] enable_i, clear_i, request_i;
   logic [N-1:0] green_o, red_o, done_o, pending_o;
   logic tick_o;
   logic [4*N:0] dutv;

   int checks = 0;
   int errors = 0;

   // model: phase 0 waiting, 1 crossing (green+flash), 2 finished, 3 clearing
   int  mph [N];
   int  mt  [N];
   bit  mpend [N];
   bit  msvc_q, mblink;
   int  mcyc;

   localparam logic [4*N:0] RESET_VEC = {{N{1'b0}}, {N{1'b1}}, {N{1'b0}}, {N{1'b0}}, 1'b0};

   pedestrian_crossing_ctrl #(
      .N_CH(N), .TICK_DIV(TD), .GREEN_SEC(GS), .FLASH_SEC(FS),
      .MIN_RED_SEC(MRS), .REQ_MODE(RQM), .CNT_W(6)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .service_i(service_i),
      .enable_i(enable_i), .clear_i(clear_i), .request_i(request_i),
      .green_o(green_o), .red_o(red_o), .done_o(done_o),
      .pending_o(pending_o), .tick_o(tick_o)
   );

   assign dutv = {green_o, red_o, done_o, pending_o, tick_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4*N:0] model_out();
      logic [N-1:0] g, r, d, p;
      for (int c = 0; c < N; c++) begin
         if (msvc_q) begin
            g[c] = mblink; r[c] = 1'b0; d[c] = 1'b0;
         end else begin
            g[c] = (mph[c] == 1) && ((mt[c] < GS) || (((mt[c] - GS) % 2) == 0));
            r[c] = (mph[c] != 1);
            d[c] = (mph[c] == 2);
         end
         p[c] = mpend[c];
      end
      return {g, r, d, p, ((mcyc % TD) == TD - 1)};
   endfunction

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         mph[c] = 0; mt[c] = 0; mpend[c] = 1'b0;
      end
      msvc_q = 1'b0; mblink = 1'b0; mcyc = 0;
   endtask

   task automatic model_step();
      bit tk;
      tk = ((mcyc % TD) == TD - 1);
      for (int c = 0; c < N; c++) begin
         if (service_i) begin
            mph[c] = 0; mt[c] = 0; mpend[c] = 1'b0;
         end else begin
            case (mph[c])
               0: begin
                  if (enable_i[c] && (mpend[c] || RQM == 0)) begin
                     mph[c] = 1; mt[c] = 0; mpend[c] = 1'b0;
                  end else if (request_i[c]) begin
                     mpend[c] = 1'b1;
                  end
               end
               1: begin
                  if (request_i[c] && mt[c] >= GS) mpend[c] = 1'b1;
                  if (tk) begin
                     mt[c]++;
                     if (mt[c] == GS + FS) begin mph[c] = 2; mt[c] = 0; end
                  end
               end
               2: begin
                  if (request_i[c]) mpend[c] = 1'b1;
                  if (clear_i[c]) begin mph[c] = (MRS > 0) ? 3 : 0; mt[c] = 0; end
               end
               default: begin
                  if (request_i[c]) mpend[c] = 1'b1;
                  if (tk) begin
                     mt[c]++;
                     if (mt[c] == MRS) begin mph[c] = 0; mt[c] = 0; end
                  end
               end
            endcase
         end
      end
      if (!msvc_q) mblink = 1'b0;
      else if (tk) mblink = ~mblink;
      msvc_q = service_i;
      mcyc++;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b1; service_i = 1'b0;
      enable_i = '0; clear_i = '0; request_i = '0;
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset_i = 1'b1; service_i = 1'b0;
      enable_i = '1; clear_i = '1; request_i = '1;
      #12;
      checks++;
      if (dutv !== RESET_VEC) begin
         errors++; $display("FAIL reset_state: dut=%b expected=%b", dutv, RESET_VEC);
      end
      do_reset();
   endtask

   task automatic test_no_request();
      do_reset();
      enable_i = 2'b01;
      for (int n = 0; n < 40; n++) begin
         step();
         checks++;
         if (dutv !== model_out() || red_o[0] !== 1'b1) begin
            errors++; $display("FAIL no_request cyc%0d: dut=%b model=%b", n, dutv, model_out());
         end
      end
   endtask

   task automatic test_phase();
      do_reset();
      enable_i = 2'b01;
      request_i = 2'b01;
      step();
      request_i = '0;
      for (int n = 0; n < 400 && !done_o[0]; n++) begin
         step();
         checks++;
         if (dutv !== model_out()) begin
            errors++; $display("FAIL phase cyc%0d: dut=%b model=%b", n, dutv, model_out());
         end
      end
      checks++;
      if (done_o[0] !== 1'b1 || pending_o[0] !== 1'b0) begin
         errors++; $display("FAIL phase_done: done=%b pending=%b expected done=1 pending=0", done_o[0], pending_o[0]);
      end
   endtask

   task automatic test_hold();
      int cyc;
      // continues from DONE on ch0 with enable held
      request_i = 2'b01;
      step();
      request_i = '0;
      clear_i = 2'b01;
      step();
      clear_i = '0;
      cyc = 1;
      for (int n = 0; n < 60 && !green_o[0]; n++) begin
         checks++;
         if (dutv !== model_out() || red_o[0] !== 1'b1) begin
            errors++; $display("FAIL hold cyc%0d: dut=%b model=%b", n, dutv, model_out());
         end
         step();
         cyc++;
      end
      checks++;
      if (green_o[0] !== 1'b1 || cyc < 2 * TD + 2 || cyc > 3 * TD + 1) begin
         errors++; $display("FAIL hold_len: green=%b cycles=%0d expected green=1 within %0d..%0d",
                            green_o[0], cyc, 2 * TD + 2, 3 * TD + 1);
      end
   endtask

   task automatic test_service();
      do_reset();
      enable_i = 2'b10;
      request_i = 2'b10;
      step();
      request_i = '0;
      for (int n = 0; n < 300 && !(mph[1] == 1 && mt[1] >= GS + 2); n++) begin
         step();
         checks++;
         if (dutv !== model_out()) begin
            errors++; $display("FAIL svc_pre cyc%0d: dut=%b model=%b", n, dutv, model_out());
         end
      end
      service_i = 1'b1;
      for (int n = 0; n < 35; n++) begin
         step();
         checks++;
         if (dutv !== model_out() || red_o !== 2'b00 || done_o !== 2'b00) begin
            errors++; $display("FAIL svc cyc%0d: dut=%b model=%b", n, dutv, model_out());
         end
      end
      service_i = 1'b0;
      enable_i = '0;
      for (int n = 0; n < 15; n++) begin
         step();
         checks++;
         if (dutv !== model_out() || red_o !== 2'b11) begin
            errors++; $display("FAIL svc_release cyc%0d: dut=%b model=%b", n, dutv, model_out());
         end
      end
   endtask

   task automatic test_req_in_green();
      bit second;
      do_reset();
      enable_i = 2'b01;
      request_i = 2'b01;
      step();
      request_i = '0;
      second = 1'b0;
      for (int n = 0; n < 700; n++) begin
         request_i[0] = (mph[0] == 1) && (mt[0] == 3 || mt[0] == GS + 1) && (n % 7 == 0);
         clear_i[0] = done_o[0];
         step();
         if (mph[0] == 1 && mt[0] == GS + 5) second = second | (n > 250);
         checks++;
         if (dutv !== model_out()) begin
            errors++; $display("FAIL req_green cyc%0d: dut=%b model=%b", n, dutv, model_out());
         end
      end
      request_i = '0; clear_i = '0;
      checks++;
      if (!second) begin
         errors++; $display("FAIL req_second_phase: second phase seen=%0b expected 1", second);
      end
   endtask

   task automatic test_async_reset();
      int first;
      do_reset();
      enable_i = 2'b01;
      request_i = 2'b01;
      step();
      request_i = '0;
      for (int n = 0; n < 20; n++) step();
      checks++;
      if (green_o[0] !== 1'b1) begin
         errors++; $display("FAIL areset_pre: green=%b expected 1", green_o[0]);
      end
      @(posedge clk);
      #3;
      reset_i = 1'b1;
      #1;
      checks++;
      if (dutv !== RESET_VEC) begin
         errors++; $display("FAIL areset_now: dut=%b expected=%b", dutv, RESET_VEC);
      end
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      model_reset();
      first = 0;
      for (int k = 1; k <= 3 * TD && first == 0; k++) begin
         if (tick_o === 1'b1) first = k;
         else step();
      end
      checks++;
      if (first != TD) begin
         errors++; $display("FAIL areset_tick: first tick cycle=%0d expected %0d", first, TD);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < N; c++) begin
            request_i[c] = ($urandom_range(0, 15) == 0);
            clear_i[c]   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 59) == 0) enable_i[c] = ~enable_i[c];
         end
         if (!service_i) service_i = ($urandom_range(0, 399) == 0);
         else service_i = ($urandom_range(0, 29) != 0);
         step();
         checks++;
         if (dutv !== model_out()) begin
            errors++; $display("FAIL random cyc%0d: dut=%b model=%b", n, dutv, model_out());
         end
      end
   endtask

   initial begin
      reset_i = 1'b1; service_i = 1'b0;
      enable_i = '0; clear_i = '0; request_i = '0;
      model_reset();
      test_reset();
      test_no_request();
      test_phase();
      test_hold();
      test_service();
      test_req_in_green();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
